// File: rtl/sprite_reg_writer_if.sv
// Avalon-MM write-only register bus between sprite_reg_writer (master) and
// the VGA sprite/ball display peripheral (slave).
interface sprite_reg_writer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              avm_chipselect;
  logic              avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_chipselect,
    output avm_write,
    output avm_address,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_chipselect,
    input  avm_write,
    input  avm_address,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sprite_reg_writer.sv
// Queues (addr, data, last) register updates and replays them as Avalon-MM writes.
// Define VBLANK_GATE_EN to start transfers only while vblank is high.
module sprite_reg_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDR_W-1:0]               in_addr,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_last,
  input  logic                            vblank,
  sprite_reg_writer_if.master             avm,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            batch_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]        state;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              full;
  logic              push;
  logic              pop;
  logic              gate;
  logic              start_ok;
  logic              complete;
  logic              cs_r;
  logic              last_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;

`ifdef VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate          = 1'b1;
`endif

  assign full     = (count == CW'(FIFO_DEPTH));
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign start_ok = (count != '0) && gate;
  assign complete = (state == WRITE) && !avm.avm_waitrequest;
  // A new entry is loaded from IDLE or on the completing edge of the current write.
  assign pop      = start_ok && ((state == IDLE) || complete);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, in_addr, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cs_r       <= 1'b0;
      last_r     <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= complete && last_r;
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= WRITE;
            cs_r  <= 1'b1;
          end
        end
        WRITE: begin
          if (complete && !pop) begin
            state <= IDLE;
            cs_r  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cs_r  <= 1'b0;
        end
      endcase
      if (pop) begin
        {last_r, addr_r, data_r} <= head;
      end
    end
  end

  assign avm.avm_chipselect = cs_r;
  assign avm.avm_write      = cs_r;
  assign avm.avm_address    = addr_r;
  assign avm.avm_writedata  = data_r;

  assign fifo_count = count;
  assign busy       = (count != '0) || (state == WRITE);

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Directed bench for sprite_reg_writer: a per-cycle vector table plus
// hand-written full-FIFO, reset-mid-burst and (optionally) vblank-gating sequences.
module tb_sprite_reg_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_addr;
  logic [7:0] in_data;
  logic       in_last;
  logic       vblank;
  logic [4:0] fifo_count;
  logic       busy;
  logic       batch_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_reg_writer_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  sprite_reg_writer #(.FIFO_DEPTH(16), .ADDR_W(6), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_last    (in_last),
    .vblank     (vblank),
    .avm        (bus.master),
    .fifo_count (fifo_count),
    .busy       (busy),
    .batch_done (batch_done)
  );

  typedef struct {
    logic       v;
    logic [5:0] a;
    logic [7:0] d;
    logic       l;
    logic       wr;
    logic       ew;
    logic [5:0] ea;
    logic [7:0] ed;
    logic       ebd;
    logic [4:0] ec;
    logic       eb;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int i, input logic v, input logic [5:0] a, input logic [7:0] d,
                     input logic l, input logic wr, input logic ew, input logic [5:0] ea,
                     input logic [7:0] ed, input logic ebd, input logic [4:0] ec, input logic eb);
    tbl[i] = '{v, a, d, l, wr, ew, ea, ed, ebd, ec, eb};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int seen;

    // single write
    add(0,  1, 3,  8'hC8, 1, 0,  0, 0,  8'h00, 0, 1, 1);
    add(1,  0, 0,  8'h00, 0, 0,  1, 3,  8'hC8, 0, 0, 1);
    add(2,  0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 1, 0, 0);
    add(3,  0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 0, 0, 0);
    // burst of five
    add(4,  1, 3,  8'h10, 0, 0,  0, 0,  8'h00, 0, 1, 1);
    add(5,  1, 4,  8'h11, 0, 0,  1, 3,  8'h10, 0, 1, 1);
    add(6,  1, 5,  8'h12, 0, 0,  1, 4,  8'h11, 0, 1, 1);
    add(7,  1, 6,  8'h13, 0, 0,  1, 5,  8'h12, 0, 1, 1);
    add(8,  1, 27, 8'h14, 1, 0,  1, 6,  8'h13, 0, 1, 1);
    add(9,  0, 0,  8'h00, 0, 0,  1, 27, 8'h14, 0, 0, 1);
    add(10, 0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 1, 0, 0);
    add(11, 0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 0, 0, 0);
    // waitrequest held for three cycles on the second write
    add(12, 1, 1,  8'hAA, 0, 0,  0, 0,  8'h00, 0, 1, 1);
    add(13, 1, 2,  8'h55, 1, 0,  1, 1,  8'hAA, 0, 1, 1);
    add(14, 0, 0,  8'h00, 0, 0,  1, 2,  8'h55, 0, 0, 1);
    add(15, 0, 0,  8'h00, 0, 1,  1, 2,  8'h55, 0, 0, 1);
    add(16, 0, 0,  8'h00, 0, 1,  1, 2,  8'h55, 0, 0, 1);
    add(17, 0, 0,  8'h00, 0, 1,  1, 2,  8'h55, 0, 0, 1);
    add(18, 0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 1, 0, 0);
    add(19, 0, 0,  8'h00, 0, 0,  0, 0,  8'h00, 0, 0, 0);

    reset = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_last = 1'b0;
    vblank = 1'b1;
    bus.avm_waitrequest = 1'b0;

    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_write", 32'(bus.avm_write), 0);
    chk("rst_cs", 32'(bus.avm_chipselect), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bd", 32'(batch_done), 0);
    chk("rst_addr", 32'(bus.avm_address), 0);
    chk("rst_data", 32'(bus.avm_writedata), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      in_valid = tbl[i].v;
      in_addr  = tbl[i].a;
      in_data  = tbl[i].d;
      in_last  = tbl[i].l;
      bus.avm_waitrequest = tbl[i].wr;
      tick();
      chk($sformatf("v%0d_write", i), 32'(bus.avm_write), 32'(tbl[i].ew));
      chk($sformatf("v%0d_cs", i), 32'(bus.avm_chipselect), 32'(tbl[i].ew));
      chk($sformatf("v%0d_bd", i), 32'(batch_done), 32'(tbl[i].ebd));
      chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tbl[i].ec));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 1);
      if (tbl[i].ew) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.avm_address), 32'(tbl[i].ea));
        chk($sformatf("v%0d_data", i), 32'(bus.avm_writedata), 32'(tbl[i].ed));
      end
    end

    // Full FIFO: stall the slave so entry 0 sits in flight and 16 fill the FIFO.
    bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_addr  = 6'(k);
      in_data  = 8'(8'h80 + k);
      in_last  = (k == 16);
      #1;
      chk($sformatf("full_ready_%0d", k), 32'(in_ready), 1);
      tick();
    end
    chk("full_count", 32'(fifo_count), 16);
    chk("full_ready_low", 32'(in_ready), 0);
    chk("full_inflight", 32'(bus.avm_address), 0);
    in_addr = 6'd63;
    in_data = 8'hFF;
    in_last = 1'b0;
    tick();
    tick();
    chk("full_refused", 32'(fifo_count), 16);
    in_valid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    got = 0;
    for (int c = 0; c < 40 && got < 17; c++) begin
      if (bus.avm_write && !bus.avm_waitrequest) begin
        chk($sformatf("drain_addr_%0d", got), 32'(bus.avm_address), 32'(got));
        chk($sformatf("drain_data_%0d", got), 32'(bus.avm_writedata), 32'(8'h80 + got));
        got++;
      end
      tick();
    end
    chk("drain_total", 32'(got), 17);
    chk("drain_bd", 32'(batch_done), 1);
    chk("drain_write_low", 32'(bus.avm_write), 0);
    chk("drain_ready", 32'(in_ready), 1);
    chk("drain_count", 32'(fifo_count), 0);
    tick();

    // Reset mid-burst: one write stalled in flight, four queued.
    bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_addr  = 6'(40 + k);
      in_data  = 8'(k);
      in_last  = (k == 4);
      tick();
    end
    in_valid = 1'b0;
    chk("rmid_write", 32'(bus.avm_write), 1);
    chk("rmid_count", 32'(fifo_count), 4);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_write_drop", 32'(bus.avm_write), 0);
    chk("rmid_cs_drop", 32'(bus.avm_chipselect), 0);
    chk("rmid_count0", 32'(fifo_count), 0);
    chk("rmid_ready0", 32'(in_ready), 0);
    chk("rmid_busy0", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.avm_write) seen++;
    end
    chk("rmid_no_writes", 32'(seen), 0);
    chk("rmid_ready1", 32'(in_ready), 1);

`ifdef VBLANK_GATE_EN
    vblank = 1'b0;
    in_valid = 1'b1;
    in_addr = 6'd10;
    in_data = 8'h01;
    in_last = 1'b0;
    tick();
    in_addr = 6'd11;
    in_data = 8'h02;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("gate_hold_write", 32'(bus.avm_write), 0);
    chk("gate_hold_count", 32'(fifo_count), 2);
    vblank = 1'b1;
    tick();
    chk("gate_open_write", 32'(bus.avm_write), 1);
    chk("gate_open_addr", 32'(bus.avm_address), 10);
    chk("gate_open_count", 32'(fifo_count), 1);
    bus.avm_waitrequest = 1'b1;
    vblank = 1'b0;
    tick();
    chk("gate_mid_hold", 32'(bus.avm_write), 1);
    bus.avm_waitrequest = 1'b0;
    tick();
    chk("gate_mid_done", 32'(bus.avm_write), 0);
    chk("gate_mid_count", 32'(fifo_count), 1);
    tick();
    chk("gate_mid_wait", 32'(bus.avm_write), 0);
    vblank = 1'b1;
    tick();
    chk("gate_second_write", 32'(bus.avm_write), 1);
    chk("gate_second_addr", 32'(bus.avm_address), 11);
    chk("gate_second_data", 32'(bus.avm_writedata), 8'h02);
    tick();
    chk("gate_bd", 32'(batch_done), 1);
    chk("gate_busy", 32'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
